cache_controller: RTL and testbench

Control FSM for the cache memory datapath; sits directly upstream of it and sequences every CPU load/store. Drives the datapath select and write-enable lines from the datapath's `hit`/`dirty_bit` status. Runs fixed-latency main-memory transfers: dirty-victim write-back, then line fill, then re-compare. Signals completion to the CPU with a one-cycle `cpu_done` pulse.

---
 rtl/cache_ctrl_pkg.sv | 13 +
 rtl/cache_controller_timer.sv | 28 ++
 rtl/cache_controller.sv | 133 +++++++++++++
 tb/tb_cache_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache controller FSM and its memory timer.
package cache_ctrl_pkg;

   localparam int CACHE_CTRL_DEF_LATENCY = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COMPARE   = 2'd1,
      WRITEBACK = 2'd2,
      ALLOCATE  = 2'd3
   } cache_ctrl_state_t;

endpackage

// File: rtl/cache_controller_timer.sv
// Fixed-latency memory transfer timer: counts 0..MEM_LATENCY-1 while start is high,
// flags the final count and wraps to 0 so back-to-back transfers need no extra clear.
module mem_latency_timer
   import cache_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY = CACHE_CTRL_DEF_LATENCY
) (
   input  logic clk,
   input  logic start,
   input  logic clear,
   output logic last
);

   localparam int TW = $clog2(MEM_LATENCY + 1);

   logic [TW-1:0] r_count;

   assign last = start && (r_count == TW'(MEM_LATENCY - 1));

   always_ff @(posedge clk) begin
      if (clear) begin
         r_count <= '0;
      end else if (start) begin
         r_count <= last ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/cache_controller.sv
// Cache control FSM: hit/miss sequencing, dirty write-back, line fill and re-compare.
// Optional hit/miss/write-back counters are compiled in with CACHE_CTRL_STATS_EN.
module cache_controller
   import cache_ctrl_pkg::*;
#(
   parameter int MEM_LATENCY = CACHE_CTRL_DEF_LATENCY
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic        cpu_is_byte,
   input  logic        hit,
   input  logic        dirty_bit,
   output logic        cpu_done,
   output logic        busy,
   output logic        cache_we,
   output logic        cache_in_select,
   output logic        mem_in_select,
   output logic        is_byte,
   output logic        mem_we,
   output logic        mem_re
`ifdef CACHE_CTRL_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
   output logic [31:0] wb_count
`endif
);

   cache_ctrl_state_t r_state;
   logic              r_we;
   logic              r_byte;
   logic              w_mem_active;
   logic              w_last;

   assign w_mem_active = (r_state == WRITEBACK) || (r_state == ALLOCATE);

   mem_latency_timer #(
      .MEM_LATENCY(MEM_LATENCY)
   ) u_timer (
      .clk  (clk),
      .start(w_mem_active),
      .clear(rst_b),
      .last (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst_b) begin
         r_state <= IDLE;
         r_we    <= 1'b0;
         r_byte  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cpu_req) begin
                  r_we    <= cpu_we;
                  r_byte  <= cpu_is_byte;
                  r_state <= COMPARE;
               end
            end
            COMPARE: begin
               if (hit)            r_state <= IDLE;
               else if (dirty_bit) r_state <= WRITEBACK;
               else                r_state <= ALLOCATE;
            end
            WRITEBACK: if (w_last) r_state <= ALLOCATE;
            ALLOCATE:  if (w_last) r_state <= COMPARE;
            default:   r_state <= IDLE;
         endcase
      end
   end

   // The store lands in the same cycle as the hit, so cpu_done and the write coincide.
   always_comb begin
      cpu_done        = 1'b0;
      busy            = (r_state != IDLE);
      cache_we        = 1'b0;
      cache_in_select = 1'b0;
      mem_in_select   = 1'b0;
      is_byte         = 1'b0;
      mem_we          = 1'b0;
      mem_re          = 1'b0;
      case (r_state)
         COMPARE: begin
            if (hit) begin
               cpu_done        = 1'b1;
               cache_we        = r_we;
               cache_in_select = r_we;
               is_byte         = r_we && r_byte;
            end
         end
         WRITEBACK: begin
            mem_in_select = 1'b1;
            mem_we        = 1'b1;
         end
         ALLOCATE: begin
            mem_re   = 1'b1;
            cache_we = w_last;
         end
         default: ;
      endcase
   end

`ifdef CACHE_CTRL_STATS_EN
   logic r_refilled;

   // A hit that follows this request's own fill is not a true hit.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         hit_count  <= '0;
         miss_count <= '0;
         wb_count   <= '0;
         r_refilled <= 1'b0;
      end else begin
         if (r_state == IDLE) begin
            r_refilled <= 1'b0;
         end else if ((r_state == ALLOCATE) && w_last) begin
            r_refilled <= 1'b1;
         end
         if (r_state == COMPARE) begin
            if (!hit) begin
               miss_count <= miss_count + 32'd1;
               if (dirty_bit) wb_count <= wb_count + 32'd1;
            end else if (!r_refilled) begin
               hit_count <= hit_count + 32'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized scoreboard bench for cache_controller: a driver pushes the expected
// per-request outcome, a monitor pops and checks it whenever cpu_done pulses.
module tb_cache_controller;
   import cache_ctrl_pkg::*;

   localparam int L = 4;

   logic clk = 1'b0;
   logic rst_b, cpu_req, cpu_we, cpu_is_byte, hit, dirty_bit;
   logic cpu_done, busy, cache_we, cache_in_select, mem_in_select, is_byte, mem_we, mem_re;
`ifdef CACHE_CTRL_STATS_EN
   logic [31:0] hit_count, miss_count, wb_count;
`endif

   cache_controller #(.MEM_LATENCY(L)) dut (
      .clk            (clk),
      .rst_b          (rst_b),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_is_byte    (cpu_is_byte),
      .hit            (hit),
      .dirty_bit      (dirty_bit),
      .cpu_done       (cpu_done),
      .busy           (busy),
      .cache_we       (cache_we),
      .cache_in_select(cache_in_select),
      .mem_in_select  (mem_in_select),
      .is_byte        (is_byte),
      .mem_we         (mem_we),
      .mem_re         (mem_re)
`ifdef CACHE_CTRL_STATS_EN
      ,
      .hit_count      (hit_count),
      .miss_count     (miss_count),
      .wb_count       (wb_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int issue;
      int lat;
      bit we;
      bit byt;
      int n_wr;
      int n_rd;
      int n_fill;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   fill_cnt = 0;
   int   fill_base = 0;
   bit   line_present = 1'b0;
   int   m_hit = 0, m_miss = 0, m_wb = 0;
   int   n_txn = 0;

   // Datapath model: the line is present if it was at issue time or a fill has landed since.
   assign hit = line_present || (fill_cnt != fill_base);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cache_we && !cache_in_select) fill_cnt <= fill_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input bit we, input bit byt, input bit present, input bit dirty);
      exp_t e;
      int   k;
      cpu_req      = 1'b1;
      cpu_we       = we;
      cpu_is_byte  = byt;
      line_present = present;
      dirty_bit    = dirty;
      fill_base    = fill_cnt;
      e.issue  = cyc + 1;
      e.lat    = present ? 1 : (dirty ? 2 * L + 2 : L + 2);
      e.we     = we;
      e.byt    = byt;
      e.n_wr   = (!present && dirty) ? L : 0;
      e.n_rd   = present ? 0 : L;
      e.n_fill = present ? 0 : 1;
      if (present) m_hit++;
      else begin
         m_miss++;
         if (dirty) m_wb++;
      end
      sb.push_back(e);
      @(posedge clk);
      #1 cpu_req = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (busy && k < 100);
      if (k >= 100) chk("wait_idle_timeout", 1, 0);
   endtask

   // Monitor
   initial begin
      int   n_wr = 0, n_rd = 0, n_fill = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_we) begin
            n_wr++;
            chk("wb_mem_in_select", int'(mem_in_select), 1);
         end
         if (mem_re) begin
            n_rd++;
            chk("fill_mem_in_select", int'(mem_in_select), 0);
         end
         if (cache_we && !cache_in_select) begin
            n_fill++;
            chk("fill_is_byte", int'(is_byte), 0);
            chk("fill_during_mem_re", int'(mem_re), 1);
         end
         if (cpu_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_cpu_done", 1, 0);
            end else begin
               e = sb.pop_front();
               n_txn++;
               $display("txn %0d: we=%0b byte=%0b lat=%0d wr=%0d rd=%0d fill=%0d",
                        n_txn, e.we, e.byt, cyc - e.issue + 1, n_wr, n_rd, n_fill);
               chk("latency", cyc - e.issue + 1, e.lat);
               chk("done_cache_we", int'(cache_we), int'(e.we));
               chk("done_cache_in_select", int'(cache_in_select), int'(e.we));
               chk("done_is_byte", int'(is_byte), int'(e.we && e.byt));
               chk("mem_we_cycles", n_wr, e.n_wr);
               chk("mem_re_cycles", n_rd, e.n_rd);
               chk("fill_writes", n_fill, e.n_fill);
            end
         end
         if (!busy) begin
            n_wr = 0;
            n_rd = 0;
            n_fill = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk_stats(input string tag);
`ifdef CACHE_CTRL_STATS_EN
      chk({tag, "_hit_count"}, int'(hit_count), m_hit);
      chk({tag, "_miss_count"}, int'(miss_count), m_miss);
      chk({tag, "_wb_count"}, int'(wb_count), m_wb);
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   initial begin
      rst_b = 1'b1;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_is_byte = 1'b0;
      dirty_bit = 1'b0;
      repeat (2) @(negedge clk);
      rst_b = 1'b0;
      @(negedge clk);
      chk("rst_cpu_done", int'(cpu_done), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cache_we", int'(cache_we), 0);
      chk("rst_cache_in_select", int'(cache_in_select), 0);
      chk("rst_mem_in_select", int'(mem_in_select), 0);
      chk("rst_is_byte", int'(is_byte), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_mem_re", int'(mem_re), 0);
      chk_stats("rst");

      // Directed cases from the test plan: load hit, store-byte hit, clean miss, dirty miss.
      issue(1'b0, 1'b0, 1'b1, 1'b0);
      issue(1'b1, 1'b1, 1'b1, 1'b0);
      issue(1'b0, 1'b0, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      chk_stats("random");

      // Reset in the 2nd write-back cycle: access is abandoned without cpu_done.
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_we = 1'b1;
      cpu_is_byte = 1'b0;
      line_present = 1'b0;
      dirty_bit = 1'b1;
      fill_base = fill_cnt;
      @(posedge clk);
      #1 cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_in_writeback", int'(mem_we), 1);
      rst_b = 1'b1;
      @(negedge clk);
      chk("abort_busy", int'(busy), 0);
      chk("abort_mem_we", int'(mem_we), 0);
      chk("abort_mem_re", int'(mem_re), 0);
      chk("abort_mem_in_select", int'(mem_in_select), 0);
      chk("abort_cpu_done", int'(cpu_done), 0);
      rst_b = 1'b0;
      m_hit = 0;
      m_miss = 0;
      m_wb = 0;

      @(negedge clk);
      issue(1'b1, 1'b1, 1'b0, 1'b1);
      chk_stats("dirty_store");
      issue(1'b0, 1'b0, 1'b1, 1'b1);
      issue(1'b1, 1'b1, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      chk_stats("final");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
